nn_layer_sequencer: RTL and testbench

//  Top-level scheduler for the inference datapath. Runs NUM_LAYERS layer engines (conv, FC1, FC2, ...) in a fixed order.

---
 rtl/nn_layer_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
// Sequences NUM_LAYERS layer engines in fixed order. Each engine gets an
// enable and an active-low synchronous clear. The sequencer watches each
// engine's done, owns the shared weight-ROM address port and drives the
// ping-pong activation-RAM bank select. A watchdog flags any engine that
// stalls in RUN.
// Every output is registered. The outputs are decoded from the next-state
// values, so they change on the same edge as the state register.
module nn_layer_sequencer #(
   parameter  int NUM_LAYERS = 3,
   parameter  int ADDR_W     = 11,
   parameter  int CLR_CYC    = 2,
   parameter  int WDOG_W     = 16,
   localparam int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                         clk,
   input  logic                         iRst,
   input  logic                         iStart,
   input  logic [NUM_LAYERS-1:0]        iLayerDone,
   input  logic [NUM_LAYERS*ADDR_W-1:0] iAddrFromLayer,
   output logic [NUM_LAYERS-1:0]        oLayerEna,
   output logic [NUM_LAYERS-1:0]        oLayerRst_n,
   output logic [ADDR_W-1:0]            oAddrToRom,
   output logic                         oRamBank,
   output logic [LAYER_W-1:0]           oCurLayer,
   output logic                         oBusy,
   output logic                         oDone,
   output logic                         oTimeout
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_RUN     = 3'd2,
      ST_ADVANCE = 3'd3,
      ST_FINISH  = 3'd4,
      ST_ERROR   = 3'd5
   } state_t;

   localparam logic [3:0]         CLR_LAST   = 4'(CLR_CYC - 1);
   localparam logic [WDOG_W-1:0]  WDOG_MAX   = {WDOG_W{1'b1}};
   localparam logic [WDOG_W-1:0]  WDOG_ONE   = {{(WDOG_W-1){1'b0}}, 1'b1};
   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

   state_t                  state_r, state_s;
   logic [LAYER_W-1:0]      layer_r, layer_s;
   logic                    bank_r, bank_s;
   logic [3:0]              clr_cnt_r, clr_cnt_s;
   logic [WDOG_W-1:0]       wdog_r, wdog_s, wdog_inc_s;
   logic [NUM_LAYERS-1:0]   ena_r, ena_s;
   logic [NUM_LAYERS-1:0]   rst_n_r, rst_n_s;
   logic [ADDR_W-1:0]       addr_r, addr_s;
   logic                    busy_r, busy_s;
   logic                    done_r, done_s;
   logic                    tmo_r, tmo_s;

   // One-hot decode of a layer index
   function automatic logic [NUM_LAYERS-1:0] layer_onehot(input logic [LAYER_W-1:0] idx);
      logic [NUM_LAYERS-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         if (idx == LAYER_W'(k)) begin
            v[k] = 1'b1;
         end else begin
            v[k] = 1'b0;
         end
      end
      return v;
   endfunction

   // Next-state logic, then the output decode of that next state
   always_comb begin
      state_s    = state_r;
      layer_s    = layer_r;
      bank_s     = bank_r;
      clr_cnt_s  = clr_cnt_r;
      wdog_s     = wdog_r;
      wdog_inc_s = wdog_r + WDOG_ONE;
      case (state_r)
         ST_IDLE, ST_FINISH, ST_ERROR: begin
            if (iStart) begin
               state_s   = ST_CLEAR;
               layer_s   = '0;
               bank_s    = 1'b0;
               clr_cnt_s = 4'd0;
               wdog_s    = '0;
            end else begin
               state_s = state_r;
            end
         end
         ST_CLEAR: begin
            // iLayerDone is deliberately ignored while the engine is being cleared
            if (clr_cnt_r == CLR_LAST) begin
               state_s   = ST_RUN;
               clr_cnt_s = 4'd0;
               wdog_s    = '0;
            end else begin
               clr_cnt_s = clr_cnt_r + 4'd1;
            end
         end
         ST_RUN: begin
            // done has priority over a watchdog expiry in the same cycle
            if (iLayerDone[layer_r]) begin
               state_s = ST_ADVANCE;
            end else if (wdog_inc_s == WDOG_MAX) begin
               state_s = ST_ERROR;
            end else begin
               wdog_s = wdog_inc_s;
            end
         end
         ST_ADVANCE: begin
            if (layer_r == LAST_LAYER) begin
               state_s = ST_FINISH;
            end else begin
               state_s   = ST_CLEAR;
               layer_s   = layer_r + LAYER_W'(1);
               bank_s    = ~bank_r;
               clr_cnt_s = 4'd0;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            layer_s   = '0;
            bank_s    = 1'b0;
            clr_cnt_s = 4'd0;
            wdog_s    = '0;
         end
      endcase

      ena_s   = '0;
      rst_n_s = '1;
      addr_s  = '0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      tmo_s   = 1'b0;
      case (state_s)
         ST_CLEAR: begin
            ena_s   = layer_onehot(layer_s);
            rst_n_s = ~layer_onehot(layer_s);
            addr_s  = iAddrFromLayer[layer_s*ADDR_W +: ADDR_W];
            busy_s  = 1'b1;
         end
         ST_RUN: begin
            ena_s  = layer_onehot(layer_s);
            addr_s = iAddrFromLayer[layer_s*ADDR_W +: ADDR_W];
            busy_s = 1'b1;
         end
         ST_ADVANCE: begin
            busy_s = 1'b1;
         end
         ST_FINISH: begin
            done_s = 1'b1;
         end
         ST_ERROR: begin
            tmo_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State and registered outputs; the async reset returns everything to IDLE
   always_ff @(posedge clk or posedge iRst) begin
      if (iRst) begin
         state_r   <= ST_IDLE;
         layer_r   <= '0;
         bank_r    <= 1'b0;
         clr_cnt_r <= 4'd0;
         wdog_r    <= '0;
         ena_r     <= '0;
         rst_n_r   <= '1;
         addr_r    <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         tmo_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         layer_r   <= layer_s;
         bank_r    <= bank_s;
         clr_cnt_r <= clr_cnt_s;
         wdog_r    <= wdog_s;
         ena_r     <= ena_s;
         rst_n_r   <= rst_n_s;
         addr_r    <= addr_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         tmo_r     <= tmo_s;
      end
   end

   assign oLayerEna   = ena_r;
   assign oLayerRst_n = rst_n_r;
   assign oAddrToRom  = addr_r;
   assign oRamBank    = bank_r;
   assign oCurLayer   = layer_r;
   assign oBusy       = busy_r;
   assign oDone       = done_r;
   assign oTimeout    = tmo_r;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Testbench for nn_layer_sequencer.
// The stimulus thread queues the expected sequence of output phases. A
// separate monitor pops one entry each time the DUT's visible state
// changes. It compares the outputs and how long the previous phase lasted.
// The engine model raises done dly[k] cycles after its rst_n rises. The
// watchdog is configured for 15 cycles, so the normal runs use a short
// engine latency.
module tb_nn_layer_sequencer;
   localparam int NL = 3;
   localparam int AW = 11;
   localparam int CC = 2;
   localparam int WW = 4;

   logic          clk, iRst, iStart;
   logic [NL-1:0] iLayerDone;
   logic [NL*AW-1:0] iAddrFromLayer;
   logic [NL-1:0] oLayerEna, oLayerRst_n;
   logic [AW-1:0] oAddrToRom;
   logic          oRamBank;
   logic [1:0]    oCurLayer;
   logic          oBusy, oDone, oTimeout;

   logic [NL-1:0] done_m, spur;
   int            tests, fails;
   int            dly [NL];
   bit            hang [NL];
   int            cnt [NL];
   bit            mon_en;

   typedef struct {
      logic [2:0]  ena;
      logic [2:0]  rstn;
      logic        bank;
      logic [1:0]  cur;
      logic        busy;
      logic        done;
      logic        tmo;
      logic [10:0] addr;
      int          dur;
   } rec_t;
   rec_t exp_q [$];

   assign iLayerDone = done_m | spur;

   nn_layer_sequencer #(.NUM_LAYERS(NL), .ADDR_W(AW), .CLR_CYC(CC), .WDOG_W(WW)) dut (
      .clk(clk), .iRst(iRst), .iStart(iStart), .iLayerDone(iLayerDone),
      .iAddrFromLayer(iAddrFromLayer), .oLayerEna(oLayerEna), .oLayerRst_n(oLayerRst_n),
      .oAddrToRom(oAddrToRom), .oRamBank(oRamBank), .oCurLayer(oCurLayer),
      .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout));

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] ena, input logic [2:0] rstn, input logic bank,
                       input logic [1:0] cur, input logic busy, input logic done,
                       input logic tmo, input logic [10:0] addr, input int dur);
      rec_t r;
      r.ena = ena; r.rstn = rstn; r.bank = bank; r.cur = cur; r.busy = busy;
      r.done = done; r.tmo = tmo; r.addr = addr; r.dur = dur;
      exp_q.push_back(r);
   endtask

   // CLEAR and RUN for layer k, then tail: 0 = ADVANCE, 1 = ERROR, 2 = nothing
   task automatic push_layer(input int k, input logic bank, input logic [10:0] addr,
                             input int clr_dur, input int run_dur, input int tail);
      logic [2:0] oh;
      oh = 3'b001 << k;
      push(oh, ~oh, bank, 2'(k), 1'b1, 1'b0, 1'b0, addr, clr_dur);
      push(oh, 3'b111, bank, 2'(k), 1'b1, 1'b0, 1'b0, addr, CC);
      if (tail == 0) push(3'b000, 3'b111, bank, 2'(k), 1'b1, 1'b0, 1'b0, 11'h000, run_dur);
      else if (tail == 1) push(3'b000, 3'b111, bank, 2'(k), 1'b0, 1'b0, 1'b1, 11'h000, run_dur);
   endtask

   task automatic push_normal_run(input int first_dur);
      push_layer(0, 1'b0, 11'h0AA, first_dur, 11, 0);
      push_layer(1, 1'b1, 11'h401, 1, 11, 0);
      push_layer(2, 1'b0, 11'h123, 1, 11, 0);
      push(3'b000, 3'b111, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 11'h000, 1);
   endtask

   task automatic drain(input int max_cyc, input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s: %0d expected phases still pending after %0d cycles", name, exp_q.size(), n);
         exp_q.delete();
      end
   endtask

   task automatic pulse_start();
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
   endtask

   // Engine models: done rises dly[k] cycles after rst_n rises and drops with ena
   initial begin
      done_m = '0;
      for (int k = 0; k < NL; k++) cnt[k] = 0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NL; k++) begin
            if (oLayerEna[k] && oLayerRst_n[k]) begin
               cnt[k]++;
               if (!hang[k] && cnt[k] == dly[k] + 1) done_m[k] = 1'b1;
            end else if (!oLayerEna[k]) begin
               cnt[k] = 0;
               done_m[k] = 1'b0;
            end else begin
               cnt[k] = 0;
            end
         end
      end
   end

   // Monitor: on every visible state change pop and compare one expected phase
   initial begin
      logic [11:0] prev, now;
      int   dur;
      bit   primed;
      rec_t e;
      primed = 1'b0;
      dur = 0;
      prev = '0;
      forever begin
         @(negedge clk);
         now = {oLayerEna, oLayerRst_n, oRamBank, oCurLayer, oBusy, oDone, oTimeout};
         if (!mon_en) begin
            primed = 1'b0;
         end else if (!primed) begin
            prev = now;
            dur = 1;
            primed = 1'b1;
         end else if (now != prev) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_phase: got ena=%b rst_n=%b bank=%b layer=%0d busy=%b done=%b timeout=%b",
                        oLayerEna, oLayerRst_n, oRamBank, oCurLayer, oBusy, oDone, oTimeout);
            end else begin
               e = exp_q.pop_front();
               if (e.ena !== oLayerEna || e.rstn !== oLayerRst_n || e.bank !== oRamBank ||
                   e.cur !== oCurLayer || e.busy !== oBusy || e.done !== oDone ||
                   e.tmo !== oTimeout || e.addr !== oAddrToRom || (e.dur >= 0 && e.dur != dur)) begin
                  fails++;
                  $display("FAIL phase: got ena=%b rst_n=%b bank=%b layer=%0d busy=%b done=%b timeout=%b addr=%h prev_len=%0d; expected ena=%b rst_n=%b bank=%b layer=%0d busy=%b done=%b timeout=%b addr=%h prev_len=%0d",
                           oLayerEna, oLayerRst_n, oRamBank, oCurLayer, oBusy, oDone, oTimeout, oAddrToRom, dur,
                           e.ena, e.rstn, e.bank, e.cur, e.busy, e.done, e.tmo, e.addr, e.dur);
               end
            end
            prev = now;
            dur = 1;
         end else begin
            dur++;
         end
      end
   end

   // Stimulus
   initial begin
      tests = 0; fails = 0;
      iRst = 1'b1; iStart = 1'b0; spur = '0; mon_en = 1'b0;
      for (int k = 0; k < NL; k++) begin dly[k] = 10; hang[k] = 1'b0; end
      iAddrFromLayer = {11'h123, 11'h401, 11'h0AA};
      repeat (3) @(negedge clk);
      chk("rst_ena", 32'(oLayerEna), 32'h0);
      chk("rst_rst_n", 32'(oLayerRst_n), 32'h7);
      chk("rst_addr", 32'(oAddrToRom), 32'h0);
      chk("rst_bank", 32'(oRamBank), 32'h0);
      chk("rst_layer", 32'(oCurLayer), 32'h0);
      chk("rst_flags", 32'({oBusy, oDone, oTimeout}), 32'h0);
      iRst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Full run: ena 001/010/100, bank 0/1/0, then FINISH holds
      push_normal_run(-1);
      pulse_start();
      drain(300, "full_run");
      repeat (5) @(negedge clk);
      chk("finish_hold_done", 32'(oDone), 32'h1);
      chk("finish_hold_addr", 32'(oAddrToRom), 32'h0);
      chk("finish_hold_ena", 32'(oLayerEna), 32'h0);

      // Done during CLEAR, spurious done, iStart in RUN, address latency, then a watchdog stall on layer 1
      hang[1] = 1'b1;
      push_layer(0, 1'b0, 11'h0AA, -1, 11, 0);
      push_layer(1, 1'b1, 11'h401, 1, 15, 1);
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      spur = 3'b001;
      repeat (2) @(negedge clk);
      spur = 3'b000;
      @(negedge clk);
      chk("addr_layer0", 32'(oAddrToRom), 32'h0AA);
      iAddrFromLayer[10:0] = 11'h155;
      iStart = 1'b1;
      spur = 3'b100;
      @(negedge clk);
      chk("addr_follow", 32'(oAddrToRom), 32'h155);
      chk("spurious_ena", 32'(oLayerEna), 32'h1);
      iStart = 1'b0;
      spur = 3'b000;
      iAddrFromLayer[10:0] = 11'h0AA;
      drain(300, "watchdog");
      repeat (3) @(negedge clk);
      chk("err_timeout", 32'(oTimeout), 32'h1);
      chk("err_layer", 32'(oCurLayer), 32'h1);
      chk("err_ena", 32'(oLayerEna), 32'h0);
      chk("err_addr", 32'(oAddrToRom), 32'h0);

      // Restart from ERROR; layer 0 done coincides with watchdog expiry
      hang[1] = 1'b0;
      dly[0] = 14;
      push_layer(0, 1'b0, 11'h0AA, -1, 15, 0);
      push_layer(1, 1'b1, 11'h401, 1, 11, 0);
      push_layer(2, 1'b0, 11'h123, 1, 11, 0);
      push(3'b000, 3'b111, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 11'h000, 1);
      pulse_start();
      drain(300, "restart_tie");
      dly[0] = 10;

      // Async reset in the middle of layer 1 RUN
      push_layer(0, 1'b0, 11'h0AA, -1, 11, 0);
      push_layer(1, 1'b1, 11'h401, 1, 0, 2);
      pulse_start();
      drain(300, "reach_layer1");
      @(negedge clk);
      chk("pre_reset_ena", 32'(oLayerEna), 32'h2);
      mon_en = 1'b0;
      #2;
      iRst = 1'b1;
      #1;
      chk("midrun_ena", 32'(oLayerEna), 32'h0);
      chk("midrun_rst_n", 32'(oLayerRst_n), 32'h7);
      chk("midrun_busy", 32'(oBusy), 32'h0);
      chk("midrun_state", 32'({oAddrToRom, oRamBank, oCurLayer}), 32'h0);
      @(negedge clk);
      iRst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Clean run after the reset
      push_normal_run(-1);
      pulse_start();
      drain(300, "post_reset_run");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
